// File: rtl/vproc_result_sched_pkg.sv
// Shared defaults and helpers for the XIF result-channel scheduler.
package vproc_result_sched_pkg;

    localparam int unsigned XIF_ID_W_DEF = 3;
    localparam int unsigned SRC_CNT_DEF  = 4;

    // Number of distinct instruction IDs for a given ID width
    function automatic int unsigned id_cnt(input int unsigned id_w);
        return 32'd1 << id_w;
    endfunction

endpackage

// File: rtl/vproc_result_sched_age_matrix.sv
// Pending-ID tracker with a relative-age matrix: insert one ID, remove any set of IDs,
// and report which pending IDs have no older pending ID.
module vproc_result_sched_age_matrix
    import vproc_result_sched_pkg::*;
#(
    parameter int unsigned ID_W   = XIF_ID_W_DEF,
    parameter int unsigned ID_CNT = id_cnt(ID_W)
) (
    input  logic                           clk_i,
    input  logic                           async_rst_ni,
    input  logic                           ins_valid,
    input  logic [ID_W-1:0]                ins_id,
    input  logic [ID_CNT-1:0]              remove,
    output logic [ID_CNT-1:0]              pending,
    output logic [ID_CNT-1:0][ID_CNT-1:0]  older,
    output logic [ID_CNT-1:0]              oldest
);

    logic [ID_CNT-1:0]             pending_q, pending_d, live;
    logic [ID_CNT-1:0][ID_CNT-1:0] older_q, older_d;

    // Removed IDs drop their row and column; a newly inserted ID is younger than every survivor
    always_comb begin
        live      = pending_q & ~remove;
        pending_d = live;
        older_d   = '0;
        for (int i = 0; i < int'(ID_CNT); i++) begin
            for (int j = 0; j < int'(ID_CNT); j++) begin
                older_d[i][j] = older_q[i][j] & live[i] & live[j];
            end
        end
        if (ins_valid) begin
            pending_d[ins_id] = 1'b1;
            for (int k = 0; k < int'(ID_CNT); k++) begin
                older_d[k][ins_id] = live[k];
                older_d[ins_id][k] = 1'b0;
            end
        end
    end

    always_comb begin
        oldest = '0;
        for (int i = 0; i < int'(ID_CNT); i++) begin
            oldest[i] = pending_q[i];
            for (int j = 0; j < int'(ID_CNT); j++) begin
                if (older_q[j][i]) begin
                    oldest[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            pending_q <= '0;
            older_q   <= '0;
        end else begin
            pending_q <= pending_d;
            older_q   <= older_d;
        end
    end

    assign pending = pending_q;
    assign older   = older_q;

endmodule

// File: rtl/vproc_result_sched.sv
// Age-ordered arbiter for the shared XIF result channel: grants the request carrying
// the oldest pending instruction ID and retires it on handshake.
module vproc_result_sched
    import vproc_result_sched_pkg::*;
#(
    parameter int unsigned XIF_ID_W       = XIF_ID_W_DEF,
    parameter int unsigned SRC_CNT        = SRC_CNT_DEF,
    parameter bit          ORDERED        = 1'b0,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        async_rst_ni,
    input  logic                        issue_valid_i,
    input  logic [XIF_ID_W-1:0]         issue_id_i,
    input  logic                        kill_valid_i,
    input  logic [XIF_ID_W-1:0]         kill_id_i,
    input  logic [SRC_CNT-1:0]          req_valid_i,
    input  logic [SRC_CNT*XIF_ID_W-1:0] req_id_i,
    output logic [SRC_CNT-1:0]          gnt_o,
    input  logic                        res_ready_i,
    output logic                        res_valid_o,
    output logic [$clog2(SRC_CNT)-1:0]  res_src_o,
    output logic [XIF_ID_W-1:0]         res_id_o,
    output logic [XIF_ID_W:0]           outstanding_o,
    output logic                        protocol_err_o
);

    localparam int unsigned ID_CNT = id_cnt(XIF_ID_W);
    localparam int unsigned SRC_W  = $clog2(SRC_CNT);
    localparam int unsigned CNT_W  = XIF_ID_W + 1;

    logic [ID_CNT-1:0]             pending, oldest, remove;
    logic [ID_CNT-1:0][ID_CNT-1:0] older;

    logic                sel_found;
    logic [SRC_W-1:0]    sel_src;
    logic [XIF_ID_W-1:0] sel_id, cur_id;
    logic                req_err, retire, kill_ok, kill_err, issue_err, ins_valid;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    vproc_result_sched_age_matrix #(
        .ID_W   (XIF_ID_W),
        .ID_CNT (ID_CNT)
    ) u_age_matrix (
        .clk_i        (clk_i),
        .async_rst_ni (async_rst_ni),
        .ins_valid    (ins_valid),
        .ins_id       (issue_id_i),
        .remove       (remove),
        .pending      (pending),
        .older        (older),
        .oldest       (oldest)
    );

    // Priority scan: a later source displaces the current pick only if strictly older,
    // so equal IDs resolve to the lowest source index
    always_comb begin
        sel_found = 1'b0;
        sel_src   = '0;
        sel_id    = '0;
        cur_id    = '0;
        req_err   = 1'b0;
        for (int s = 0; s < int'(SRC_CNT); s++) begin
            cur_id = req_id_i[s*XIF_ID_W +: XIF_ID_W];
            if (req_valid_i[s] && !pending[cur_id]) begin
                req_err = 1'b1;
            end
            if (req_valid_i[s] && pending[cur_id]
                && !(kill_valid_i && (kill_id_i == cur_id))
                && (!ORDERED || oldest[cur_id])
                && (!sel_found || older[cur_id][sel_id])) begin
                sel_found = 1'b1;
                sel_src   = SRC_W'(s);
                sel_id    = cur_id;
            end
        end
    end

    // Retire, kill and issue all land on the same edge; issue may reuse an ID freed this cycle
    always_comb begin
        retire   = sel_found & res_ready_i;
        kill_ok  = kill_valid_i & pending[kill_id_i];
        kill_err = kill_valid_i & ~pending[kill_id_i];
        remove   = '0;
        for (int k = 0; k < int'(ID_CNT); k++) begin
            remove[k] = (retire && (sel_id == XIF_ID_W'(k)))
                     || (kill_ok && (kill_id_i == XIF_ID_W'(k)));
        end
        issue_err = issue_valid_i & pending[issue_id_i] & ~remove[issue_id_i];
        ins_valid = issue_valid_i & ~issue_err;
        err_d     = err_q | req_err | kill_err | issue_err;
        cnt_d     = cnt_q + CNT_W'(ins_valid) - CNT_W'(retire) - CNT_W'(kill_ok);
    end

    always_comb begin
        res_valid_o = sel_found;
        res_src_o   = sel_src;
        res_id_o    = sel_id;
        gnt_o       = '0;
        if (retire) begin
            gnt_o[sel_src] = 1'b1;
        end
        if (!sel_found && !DONT_CARE_ZERO) begin
            res_src_o = 'x;
            res_id_o  = 'x;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign outstanding_o  = cnt_q;
    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_vproc_result_sched.sv
// Directed and randomized checks of the result scheduler (unordered and ordered instances)
// against an issue-timestamp reference model.
module tb_vproc_result_sched;

    localparam int ID_W = 3;
    localparam int IDS  = 8;
    localparam int SRC  = 4;

    logic             clk;
    logic             rst_n;
    logic             issue_valid;
    logic [ID_W-1:0]  issue_id;
    logic             kill_valid;
    logic [ID_W-1:0]  kill_id;
    logic [SRC-1:0]   req_valid;
    logic [SRC*ID_W-1:0] req_id;
    logic             res_ready;

    logic [SRC-1:0]   gnt       [2];
    logic             res_valid [2];
    logic [1:0]       res_src   [2];
    logic [ID_W-1:0]  res_id    [2];
    logic [ID_W:0]    outst     [2];
    logic             perr      [2];

    // reference model: per instance, pending flag, issue timestamp, sticky error
    bit          m_pend  [2][IDS];
    int unsigned m_stamp [2][IDS];
    bit          m_err   [2];
    int unsigned tick;

    int n_assert;
    int n_fail;

    vproc_result_sched #(
        .XIF_ID_W(ID_W), .SRC_CNT(SRC), .ORDERED(1'b0), .DONT_CARE_ZERO(1'b0)
    ) dut_u (
        .clk_i(clk), .async_rst_ni(rst_n),
        .issue_valid_i(issue_valid), .issue_id_i(issue_id),
        .kill_valid_i(kill_valid), .kill_id_i(kill_id),
        .req_valid_i(req_valid), .req_id_i(req_id),
        .gnt_o(gnt[0]), .res_ready_i(res_ready),
        .res_valid_o(res_valid[0]), .res_src_o(res_src[0]), .res_id_o(res_id[0]),
        .outstanding_o(outst[0]), .protocol_err_o(perr[0])
    );

    vproc_result_sched #(
        .XIF_ID_W(ID_W), .SRC_CNT(SRC), .ORDERED(1'b1), .DONT_CARE_ZERO(1'b0)
    ) dut_o (
        .clk_i(clk), .async_rst_ni(rst_n),
        .issue_valid_i(issue_valid), .issue_id_i(issue_id),
        .kill_valid_i(kill_valid), .kill_id_i(kill_id),
        .req_valid_i(req_valid), .req_id_i(req_id),
        .gnt_o(gnt[1]), .res_ready_i(res_ready),
        .res_valid_o(res_valid[1]), .res_src_o(res_src[1]), .res_id_o(res_id[1]),
        .outstanding_o(outst[1]), .protocol_err_o(perr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, m, obs, exp);
        end
    endtask

    function automatic int rid(input int s);
        return int'(req_id[s*ID_W +: ID_W]);
    endfunction

    function automatic int m_count(input int m);
        int c = 0;
        for (int i = 0; i < IDS; i++) c += int'(m_pend[m][i]);
        return c;
    endfunction

    function automatic int m_oldest(input int m);
        int o = -1;
        for (int i = 0; i < IDS; i++)
            if (m_pend[m][i] && (o < 0 || m_stamp[m][i] < m_stamp[m][o])) o = i;
        return o;
    endfunction

    // Expected selected source (-1 = none) from the current inputs and model state
    function automatic int exp_sel(input int m);
        int best = -1;
        int old  = m_oldest(m);
        for (int s = 0; s < SRC; s++) begin
            int id;
            id = rid(s);
            if (req_valid[s] && m_pend[m][id] && !(kill_valid && int'(kill_id) == id)
                && (m == 0 || id == old)
                && (best < 0 || m_stamp[m][id] < m_stamp[m][rid(best)]))
                best = s;
        end
        return best;
    endfunction

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            int sel;
            logic [31:0] eg;
            sel = exp_sel(m);
            eg  = (sel >= 0 && res_ready) ? (32'd1 << sel) : 32'd0;
            chk("res_valid", m, 32'(res_valid[m]), 32'(sel >= 0));
            if (sel >= 0) begin
                chk("res_src", m, 32'(res_src[m]), 32'(sel));
                chk("res_id", m, 32'(res_id[m]), 32'(rid(sel)));
            end
            chk("gnt", m, 32'(gnt[m]), eg);
            chk("outstanding", m, 32'(outst[m]), 32'(m_count(m)));
            chk("protocol_err", m, 32'(perr[m]), 32'(m_err[m]));
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            int sel;
            bit kok;
            sel = exp_sel(m);
            for (int s = 0; s < SRC; s++)
                if (req_valid[s] && !m_pend[m][rid(s)]) m_err[m] = 1'b1;
            kok = kill_valid && m_pend[m][kill_id];
            if (kill_valid && !kok) m_err[m] = 1'b1;
            if (sel >= 0 && res_ready) m_pend[m][rid(sel)] = 1'b0;
            if (kok) m_pend[m][kill_id] = 1'b0;
            if (issue_valid) begin
                if (m_pend[m][issue_id]) m_err[m] = 1'b1;
                else begin
                    m_pend[m][issue_id]  = 1'b1;
                    m_stamp[m][issue_id] = tick;
                end
            end
        end
        tick++;
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            m_err[m] = 1'b0;
            for (int i = 0; i < IDS; i++) m_pend[m][i] = 1'b0;
        end
    endtask

    task automatic set_idle();
        issue_valid = 1'b0; issue_id = '0;
        kill_valid  = 1'b0; kill_id  = '0;
        req_valid   = '0;   req_id   = '0;
        res_ready   = 1'b0;
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic step();
        #2;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        #2;
        for (int m = 0; m < 2; m++) begin
            chk("rst_valid", m, 32'(res_valid[m]), 32'd0);
            chk("rst_gnt", m, 32'(gnt[m]), 32'd0);
            chk("rst_outstanding", m, 32'(outst[m]), 32'd0);
            chk("rst_err", m, 32'(perr[m]), 32'd0);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input int id);
        set_idle();
        issue_valid = 1'b1;
        issue_id    = 3'(id);
        step();
    endtask

    task automatic request(input int s, input int id);
        req_valid[s]          = 1'b1;
        req_id[s*ID_W +: ID_W] = 3'(id);
    endtask

    // Fill all IDs in random order, then drain with random requests/stalls/kills.
    // Requests always include the oldest pending ID so both instances stay in step.
    task automatic burst(input bit mid_reset);
        int perm [IDS];
        for (int i = 0; i < IDS; i++) perm[i] = i;
        for (int i = IDS - 1; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < IDS; i++) issue(perm[i]);
        for (int it = 0; it < 300 && m_count(0) > 0; it++) begin
            int pl [IDS];
            int np = 0;
            int old;
            for (int i = 0; i < IDS; i++) if (m_pend[0][i]) begin pl[np] = i; np++; end
            old = m_oldest(0);
            set_idle();
            request(int'($urandom_range(0, SRC - 1)), old);
            for (int s = 0; s < SRC; s++)
                if (!req_valid[s] && $urandom_range(0, 1) == 1)
                    request(s, pl[$urandom_range(0, np - 1)]);
            res_ready = ($urandom_range(0, 3) != 0);
            if (np > 1 && $urandom_range(0, 7) == 0) begin
                int k;
                k = pl[$urandom_range(0, np - 1)];
                if (k != old) begin kill_valid = 1'b1; kill_id = 3'(k); end
            end
            if (mid_reset && it == 6) begin
                #3;
                rst_n = 1'b0;
                #1;
                for (int m = 0; m < 2; m++) begin
                    chk("mid_rst_outstanding", m, 32'(outst[m]), 32'd0);
                    chk("mid_rst_valid", m, 32'(res_valid[m]), 32'd0);
                    chk("mid_rst_gnt", m, 32'(gnt[m]), 32'd0);
                end
                model_clear();
                @(negedge clk);
                rst_n = 1'b1;
                step();
                return;
            end
            step();
        end
        set_idle();
        step();
        for (int m = 0; m < 2; m++) chk("drained", m, 32'(outst[m]), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        tick     = 0;
        set_idle();
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);

        // Oldest of 3,1,6 granted first
        do_reset();
        issue(3); issue(1); issue(6);
        set_idle(); res_ready = 1'b1;
        request(0, 6); request(1, 1); request(2, 3); step();
        req_valid[2] = 1'b0; step();
        req_valid[1] = 1'b0; step();
        set_idle(); step();

        // Ordered instance waits for ID2 before granting ID5
        do_reset();
        issue(2); issue(5);
        set_idle(); request(0, 5);
        step(); step(); step();
        kill_valid = 1'b1; kill_id = 3'd2; step();
        kill_valid = 1'b0; res_ready = 1'b1; step();
        set_idle(); step();

        // Ready stall holds the request without retiring it
        do_reset();
        issue(4);
        set_idle(); request(1, 4);
        for (int i = 0; i < 4; i++) step();
        res_ready = 1'b1; step();
        set_idle(); step();

        // Retire ID0, kill ID7 and re-issue ID0 in one cycle
        do_reset();
        issue(0); issue(7); issue(2);
        set_idle(); request(1, 0); res_ready = 1'b1;
        kill_valid = 1'b1; kill_id = 3'd7;
        issue_valid = 1'b1; issue_id = 3'd0;
        step();
        set_idle(); res_ready = 1'b1; request(0, 2); request(1, 0); step();
        req_valid[0] = 1'b0; step();
        set_idle(); step();
        for (int m = 0; m < 2; m++) chk("same_cycle_err", m, 32'(perr[m]), 32'd0);

        // Protocol errors are sticky and leave other state alone
        do_reset();
        issue(3); issue(3);
        set_idle(); request(3, 5); res_ready = 1'b1; step();
        set_idle(); request(0, 3); res_ready = 1'b1; step();
        set_idle(); kill_valid = 1'b1; kill_id = 3'd6; step();
        set_idle(); step();
        for (int m = 0; m < 2; m++) chk("err_sticky", m, 32'(perr[m]), 32'd1);

        // Random full-window drain, with and without an asynchronous reset mid-burst
        do_reset();
        burst(1'b1);
        do_reset();
        burst(1'b0);
        do_reset();
        burst(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
